// File: rtl/coproc0_v2_pkg.sv
// Shared COP0 definitions: instruction encodings, register numbers, SR/CAUSE bit positions,
// exception codes, the decode-stage pipeline record and the decode-error helper.
package coproc0_v2_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [5:0]  OP_COP0  = 6'b010000;
  localparam logic [4:0]  COP_MF   = 5'b00000;
  localparam logic [4:0]  COP_MT   = 5'b00100;
  localparam logic [4:0]  COP_CO   = 5'b10000;
  localparam logic [5:0]  FUNC_RFE = 6'b010000;

  typedef enum logic [4:0] {
    REG_COMPARE = 5'h08,
    REG_COUNT   = 5'h09,
    REG_IVT     = 5'h0A,
    REG_PSR     = 5'h0B,
    REG_SR      = 5'h0C,
    REG_CAUSE   = 5'h0D,
    REG_EPC     = 5'h0E,
    REG_PRID    = 5'h0F
  } cop0_reg_e;

  localparam int SR_IE     = 0;
  localparam int SR_IM     = 8;
  localparam int SR_TM     = 30;
  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_TI  = 30;
  localparam int CAUSE_IP  = 8;
  localparam int CAUSE_EXC = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OVF  = 5'h0C
  } exc_code_e;

  // One COP0 op travelling from decode to writeback; dat is filled in at p3.
  typedef struct packed {
    logic        mt;
    logic        rfe;
    logic [4:0]  reg_no;
    logic [31:0] dat;
  } cop0_stage_t;

  function automatic logic cop0_decode_err(input logic [31:0] instr);
    logic err;
    err = 1'b0;
    if (instr[31:26] == OP_COP0) begin
      case (instr[25:21])
        COP_MF, COP_MT: err = (instr[10:0] != 11'd0);
        COP_CO:         err = (instr[20:6] != 15'd0) || (instr[5:0] != FUNC_RFE);
        default:        err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/coproc0_v2_irq_sync.sv
// Two-flop synchroniser for the asynchronous level interrupt lines; output lags input by 2 cycles.
module cop0_irq_sync #(
  parameter int NIRQ = 6
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NIRQ-1:0] irq,
  output logic [NIRQ-1:0] irq_sync
);

  logic [NIRQ-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta     <= '0;
      irq_sync <= '0;
    end else begin
      meta     <= irq;
      irq_sync <= meta;
    end
  end

endmodule

// File: rtl/coproc0_v2.sv
// COP0 v2: decodes COP0 ops, commits MT/RFE/exception entry at writeback, raises interrupts.
// Optional COUNT/COMPARE timer is built only when COP0_TIMER_EN is defined.
module coproc0_v2 #(
  parameter int          NIRQ           = 6,
  parameter int          IE_STACK_DEPTH = 3,
  parameter int          IVT_ALIGN      = 10,
  parameter logic [31:0] PROCID         = 32'h0001_0200
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_exec_stall,
  input  logic                  i_mem_stall,
  input  logic                  i_fetch_stall,
  output logic                  o_decode_error,
  input  logic                  i_except_start,
  input  logic                  i_except_dly_slt,
  input  logic [4:0]            i_except_code,
  input  logic [31:0]           i_except_raddr,
  input  logic [31:0]           i_except_raddr_dly,
  input  logic                  i_nullify_decode,
  input  logic                  i_nullify_execute,
  input  logic                  i_nullify_mem,
  input  logic                  i_nullify_wb,
  input  logic [NIRQ-1:0]       i_irq,
  output logic                  o_irq_pending,
  output logic [31-IVT_ALIGN:0] o_cop0_ivtbase,
  output logic                  o_cop0_ie,
  input  logic [31:0]           i_instr,
  output logic                  o_cop0_op_p1,
  output logic [4:0]            o_cop0_cop_p1,
  output logic [4:0]            o_cop0_reg_no_p1,
  output logic [4:0]            o_cop0_rt_no_p1,
  output logic [31:0]           o_cop0_reg_val_p1,
  input  logic [31:0]           i_cop0_alu_result_p2
);
  import coproc0_v2_pkg::*;

  localparam int D = IE_STACK_DEPTH;

  logic                  core_stall;
  logic [31:0]           instr_p1;
  logic                  op_p1, err_p1, mt_p1, rfe_p1;
  cop0_stage_t           p2, p3, wb, p2_d, p3_d;
  logic                  wb_rfe, wb_mt, exc_take;
  logic [D-1:0]          ie_stack;
  logic [NIRQ-1:0]       im, ip;
  logic                  bd;
  logic [4:0]            exc;
  logic [31:0]           epc;
  logic [31-IVT_ALIGN:0] ivt_base;
  logic [31:0]           count, compare;
  logic                  ti, tm;
  logic [31:0]           rd_val;

  assign core_stall = i_exec_stall | i_mem_stall | i_fetch_stall;

  assign op_p1          = (instr_p1[31:26] == OP_COP0);
  assign err_p1         = cop0_decode_err(instr_p1);
  assign mt_p1          = op_p1 && !err_p1 && (instr_p1[25:21] == COP_MT);
  assign rfe_p1         = op_p1 && !err_p1 && (instr_p1[25:21] == COP_CO);
  assign o_decode_error = err_p1;
  assign o_cop0_op_p1   = op_p1;
  assign o_cop0_cop_p1  = (op_p1 && (instr_p1[25:21] == COP_MF || instr_p1[25:21] == COP_MT))
                          ? instr_p1[25:21] : 5'd0;
  assign o_cop0_rt_no_p1   = instr_p1[20:16];
  assign o_cop0_reg_no_p1  = instr_p1[15:11];
  assign o_cop0_reg_val_p1 = rd_val;

  always_comb begin
    p2_d = '0;
    if (!i_nullify_execute) begin
      p2_d.mt     = mt_p1;
      p2_d.rfe    = rfe_p1;
      p2_d.reg_no = instr_p1[15:11];
    end
    p3_d = '0;
    if (!i_nullify_mem) begin
      p3_d     = p2;
      p3_d.dat = i_cop0_alu_result_p2;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      instr_p1 <= NOP;
      p2       <= '0;
      p3       <= '0;
      wb       <= '0;
    end else if (!core_stall) begin
      instr_p1 <= i_nullify_decode ? NOP : i_instr;
      p2       <= p2_d;
      p3       <= p3_d;
      wb       <= p3;
    end
  end

  // RFE beats MT (mutually exclusive anyway); both beat exception entry.
  assign wb_rfe   = !core_stall && !i_nullify_wb && wb.rfe;
  assign wb_mt    = !core_stall && !i_nullify_wb && wb.mt;
  assign exc_take = !core_stall && !wb_rfe && !wb_mt && i_except_start;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ie_stack <= '0;
      im       <= '0;
      bd       <= 1'b0;
      exc      <= '0;
      epc      <= '0;
      ivt_base <= '0;
    end else if (wb_rfe) begin
      ie_stack <= {1'b0, ie_stack[D-1:1]};
    end else if (wb_mt) begin
      case (wb.reg_no)
        REG_IVT:   ivt_base <= wb.dat[31:IVT_ALIGN];
        REG_PSR:   ie_stack[D-1:1] <= wb.dat[D-2:0];
        REG_SR: begin
          ie_stack[0] <= wb.dat[SR_IE];
          im          <= wb.dat[SR_IM +: NIRQ];
        end
        REG_CAUSE: begin
          bd  <= wb.dat[CAUSE_BD];
          exc <= wb.dat[CAUSE_EXC +: 5];
        end
        REG_EPC:   epc <= wb.dat;
        default:   ;
      endcase
    end else if (exc_take) begin
      ie_stack <= {ie_stack[D-2:0], 1'b0};
      bd       <= i_except_dly_slt;
      epc      <= i_except_dly_slt ? i_except_raddr_dly : i_except_raddr;
      exc      <= i_except_code;
    end
  end

`ifdef COP0_TIMER_EN
  logic wr_count, wr_compare, wr_sr;

  assign wr_count   = wb_mt && (wb.reg_no == REG_COUNT);
  assign wr_compare = wb_mt && (wb.reg_no == REG_COMPARE);
  assign wr_sr      = wb_mt && (wb.reg_no == REG_SR);

  // COUNT free-runs through stalls; a committed write overrides the increment.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
      tm      <= 1'b0;
    end else begin
      count <= wr_count ? wb.dat : count + 32'd1;
      if (wr_compare) compare <= wb.dat;
      if (wr_compare) ti <= 1'b0;
      else if (count == compare - 32'd1) ti <= 1'b1;
      if (wr_sr) tm <= wb.dat[SR_TM];
    end
  end
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
  assign tm      = 1'b0;
`endif

  cop0_irq_sync #(.NIRQ(NIRQ)) u_irq_sync (
    .clk      (clk),
    .nrst     (nrst),
    .irq      (i_irq),
    .irq_sync (ip)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) o_irq_pending <= 1'b0;
    else       o_irq_pending <= ie_stack[0] & ((|(ip & im)) | (ti & tm));
  end

  always_comb begin
    rd_val = '0;
    case (instr_p1[15:11])
      REG_COMPARE: rd_val = compare;
      REG_COUNT:   rd_val = count;
      REG_IVT:     rd_val = {ivt_base, {IVT_ALIGN{1'b0}}};
      REG_PSR:     rd_val[D-2:0] = ie_stack[D-1:1];
      REG_SR: begin
        rd_val[SR_IE]          = ie_stack[0];
        rd_val[SR_IM +: NIRQ]  = im;
        rd_val[SR_TM]          = tm;
      end
      REG_CAUSE: begin
        rd_val[CAUSE_BD]         = bd;
        rd_val[CAUSE_TI]         = ti;
        rd_val[CAUSE_IP +: NIRQ] = ip;
        rd_val[CAUSE_EXC +: 5]   = exc;
      end
      REG_EPC:     rd_val = epc;
      REG_PRID:    rd_val = PROCID;
      default:     rd_val = '0;
    endcase
  end

  assign o_cop0_ie      = ie_stack[0];
  assign o_cop0_ivtbase = ivt_base;

endmodule

// File: tb/tb_coproc0_v2.sv
// Directed self-checking bench for coproc0_v2 (default parameters); timer steps follow COP0_TIMER_EN.
module tb_coproc0_v2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_exec_stall, i_mem_stall, i_fetch_stall;
  logic        o_decode_error;
  logic        i_except_start, i_except_dly_slt;
  logic [4:0]  i_except_code;
  logic [31:0] i_except_raddr, i_except_raddr_dly;
  logic        i_nullify_decode, i_nullify_execute, i_nullify_mem, i_nullify_wb;
  logic [5:0]  i_irq;
  logic        o_irq_pending;
  logic [21:0] o_cop0_ivtbase;
  logic        o_cop0_ie;
  logic [31:0] i_instr;
  logic        o_cop0_op_p1;
  logic [4:0]  o_cop0_cop_p1, o_cop0_reg_no_p1, o_cop0_rt_no_p1;
  logic [31:0] o_cop0_reg_val_p1;
  logic [31:0] i_cop0_alu_result_p2;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  localparam logic [31:0] NOP_I = 32'h0000_0000;
  localparam logic [31:0] RFE_I = 32'h4200_0010;

  coproc0_v2 dut (
    .clk(clk), .nrst(nrst),
    .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall), .i_fetch_stall(i_fetch_stall),
    .o_decode_error(o_decode_error),
    .i_except_start(i_except_start), .i_except_dly_slt(i_except_dly_slt),
    .i_except_code(i_except_code), .i_except_raddr(i_except_raddr),
    .i_except_raddr_dly(i_except_raddr_dly),
    .i_nullify_decode(i_nullify_decode), .i_nullify_execute(i_nullify_execute),
    .i_nullify_mem(i_nullify_mem), .i_nullify_wb(i_nullify_wb),
    .i_irq(i_irq), .o_irq_pending(o_irq_pending),
    .o_cop0_ivtbase(o_cop0_ivtbase), .o_cop0_ie(o_cop0_ie),
    .i_instr(i_instr), .o_cop0_op_p1(o_cop0_op_p1), .o_cop0_cop_p1(o_cop0_cop_p1),
    .o_cop0_reg_no_p1(o_cop0_reg_no_p1), .o_cop0_rt_no_p1(o_cop0_rt_no_p1),
    .o_cop0_reg_val_p1(o_cop0_reg_val_p1), .i_cop0_alu_result_p2(i_cop0_alu_result_p2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_mf(input logic [4:0] r);
    return {6'b010000, 5'b00000, 5'd0, r, 11'd0};
  endfunction

  function automatic logic [31:0] enc_mt(input logic [4:0] r);
    return {6'b010000, 5'b00100, 5'd0, r, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; wb commit happens on the 5th edge, with exc/nul applied on that edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] dat, input logic exc,
                       input logic nul);
    i_instr = ins;
    i_cop0_alu_result_p2 = dat;
    @(posedge clk); #1;
    i_instr = NOP_I;
    repeat (3) @(posedge clk);
    #1;
    i_except_start = exc;
    i_nullify_wb = nul;
    @(posedge clk); #1;
    i_except_start = 1'b0;
    i_nullify_wb = 1'b0;
  endtask

  task automatic mf(input logic [4:0] r, output logic [31:0] val);
    i_instr = enc_mf(r);
    @(posedge clk); #1;
    val = o_cop0_reg_val_p1;
    i_instr = NOP_I;
  endtask

  initial begin
    nrst = 1'b0;
    {i_exec_stall, i_mem_stall, i_fetch_stall} = 3'b000;
    i_except_start = 1'b0; i_except_dly_slt = 1'b0; i_except_code = 5'd0;
    i_except_raddr = 32'd0; i_except_raddr_dly = 32'd0;
    {i_nullify_decode, i_nullify_execute, i_nullify_mem, i_nullify_wb} = 4'b0000;
    i_irq = 6'd0;
    i_instr = NOP_I;
    i_cop0_alu_result_p2 = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending", {31'd0, o_irq_pending}, 32'd0);
    chk("rst_ie", {31'd0, o_cop0_ie}, 32'd0);
    chk("rst_ivt", {10'd0, o_cop0_ivtbase}, 32'd0);
    chk("rst_op", {31'd0, o_cop0_op_p1}, 32'd0);
    chk("rst_decerr", {31'd0, o_decode_error}, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("rst_val", o_cop0_reg_val_p1, 32'd0);

    // 1: SR write, interrupt synchronisation and pending timing
    issue(enc_mt(5'h0C), 32'h0000_0301, 1'b0, 1'b0);
    chk("sr_ie", {31'd0, o_cop0_ie}, 32'd1);
    mf(5'h0C, v); chk("sr_read", v, 32'h0000_0301);
    i_irq = 6'b000010;
    i_instr = enc_mf(5'h0D);
    @(posedge clk); #1;
    chk("ip_lag1", o_cop0_reg_val_p1, 32'h0000_0000);
    chk("pend_lag1", {31'd0, o_irq_pending}, 32'd0);
    @(posedge clk); #1;
    chk("ip_lag2", o_cop0_reg_val_p1, 32'h0000_0200);
    chk("pend_lag2", {31'd0, o_irq_pending}, 32'd0);
    @(posedge clk); #1;
    chk("pend_set", {31'd0, o_irq_pending}, 32'd1);
    i_instr = NOP_I;
    i_irq = 6'b000100;
    repeat (5) @(posedge clk);
    #1;
    chk("pend_masked", {31'd0, o_irq_pending}, 32'd0);
    i_irq = 6'd0;
    repeat (3) @(posedge clk);
    #1;

    // 2: exception in delay slot with IE stack (1,1,0), then RFE
    issue(enc_mt(5'h0B), 32'h0000_0001, 1'b0, 1'b0);
    mf(5'h0B, v); chk("psr_init", v, 32'h0000_0001);
    i_except_dly_slt = 1'b1; i_except_code = 5'h0C;
    i_except_raddr = 32'h0000_0200; i_except_raddr_dly = 32'h0000_0100;
    i_except_start = 1'b1;
    @(posedge clk); #1;
    i_except_start = 1'b0;
    chk("exc_ie", {31'd0, o_cop0_ie}, 32'd0);
    mf(5'h0E, v); chk("exc_epc", v, 32'h0000_0100);
    mf(5'h0D, v); chk("exc_cause", v, 32'h8000_0030);
    mf(5'h0B, v); chk("exc_psr", v, 32'h0000_0003);
    issue(RFE_I, 32'd0, 1'b0, 1'b0);
    chk("rfe_ie", {31'd0, o_cop0_ie}, 32'd1);
    mf(5'h0B, v); chk("rfe_psr", v, 32'h0000_0001);

    // 3: MT vs. exception in the same cycle, then with wb nullified
    i_except_dly_slt = 1'b0; i_except_code = 5'h08; i_except_raddr = 32'h0000_0200;
    issue(enc_mt(5'h0E), 32'h0000_0044, 1'b1, 1'b0);
    mf(5'h0E, v); chk("mtwin_epc", v, 32'h0000_0044);
    mf(5'h0D, v); chk("mtwin_cause", v, 32'h8000_0030);
    chk("mtwin_ie", {31'd0, o_cop0_ie}, 32'd1);
    i_except_raddr = 32'h0000_0300;
    issue(enc_mt(5'h0E), 32'h0000_0055, 1'b1, 1'b1);
    mf(5'h0E, v); chk("nul_epc", v, 32'h0000_0300);
    mf(5'h0D, v); chk("nul_cause", v, 32'h0000_0020);
    chk("nul_ie", {31'd0, o_cop0_ie}, 32'd0);
    issue(RFE_I, 32'd0, 1'b0, 1'b0);
    chk("rfe2_ie", {31'd0, o_cop0_ie}, 32'd1);

    // Exception entry is held off while the pipeline stalls
    i_mem_stall = 1'b1; i_except_raddr = 32'h0000_0400; i_except_start = 1'b1;
    @(posedge clk); #1;
    i_mem_stall = 1'b0; i_except_start = 1'b0;
    chk("stall_ie", {31'd0, o_cop0_ie}, 32'd1);
    mf(5'h0E, v); chk("stall_epc", v, 32'h0000_0300);

    // 4: IVT alignment
    issue(enc_mt(5'h0A), 32'h1234_5FFF, 1'b0, 1'b0);
    chk("ivt_base", {10'd0, o_cop0_ivtbase}, 32'h0004_8D17);
    mf(5'h0A, v); chk("ivt_read", v, 32'h1234_5C00);

    // 5: decode fields and errors
    i_instr = enc_mf(5'h0E) | 32'h0000_0001;
    @(posedge clk); #1;
    chk("mf_func_err", {31'd0, o_decode_error}, 32'd1);
    chk("mf_func_op", {31'd0, o_cop0_op_p1}, 32'd1);
    i_instr = {6'b010000, 5'b00100, 5'd3, 5'h03, 11'd0};
    @(posedge clk); #1;
    chk("mt_err", {31'd0, o_decode_error}, 32'd0);
    chk("mt_fields", {17'd0, o_cop0_cop_p1, o_cop0_rt_no_p1, o_cop0_reg_no_p1},
        {17'd0, 5'd4, 5'd3, 5'h03});
    i_instr = {6'b010000, 5'b00001, 21'd0};
    @(posedge clk); #1;
    chk("cop_err", {31'd0, o_decode_error}, 32'd1);
    i_instr = 32'h4200_0011;
    @(posedge clk); #1;
    chk("co_func_err", {31'd0, o_decode_error}, 32'd1);
    i_instr = 32'h2000_FFFF;
    @(posedge clk); #1;
    chk("noncop_op", {30'd0, o_cop0_op_p1, o_decode_error}, 32'd0);
    i_instr = RFE_I;
    @(posedge clk); #1;
    chk("rfe_dec", {26'd0, o_decode_error, o_cop0_cop_p1}, 32'd0);
    i_instr = NOP_I; i_nullify_execute = 1'b1;
    @(posedge clk); #1;
    i_nullify_execute = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mf(5'h0B, v); chk("nulex_psr", v, 32'h0000_0001);
    mf(5'h03, v); chk("unmapped_rd", v, 32'd0);
    i_instr = enc_mt(5'h0E); i_nullify_decode = 1'b1;
    @(posedge clk); #1;
    i_nullify_decode = 1'b0; i_instr = NOP_I;
    chk("nuldec_op", {31'd0, o_cop0_op_p1}, 32'd0);
    issue(enc_mt(5'h0F), 32'hDEAD_BEEF, 1'b0, 1'b0);
    mf(5'h0F, v); chk("prid", v, 32'h0001_0200);

    // 6: timer
`ifdef COP0_TIMER_EN
    issue(enc_mt(5'h08), 32'd5, 1'b0, 1'b0);
    issue(enc_mt(5'h09), 32'd0, 1'b0, 1'b0);
    issue(enc_mt(5'h08), 32'd5, 1'b0, 1'b0);
    mf(5'h0D, v); chk("ti_clear_wins", v & 32'h4000_0000, 32'd0);
    issue(enc_mt(5'h09), 32'd0, 1'b0, 1'b0);
    mf(5'h0D, v); chk("ti_early", v & 32'h4000_0000, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    mf(5'h0D, v); chk("ti_set", v & 32'h4000_0000, 32'h4000_0000);
    issue(enc_mt(5'h0C), 32'h4000_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ti_pending", {31'd0, o_irq_pending}, 32'd1);
    issue(enc_mt(5'h09), 32'hFFFF_FFFF, 1'b0, 1'b0);
    mf(5'h09, v); chk("count_wrap", v, 32'd0);
`else
    issue(enc_mt(5'h08), 32'd5, 1'b0, 1'b0);
    issue(enc_mt(5'h09), 32'd7, 1'b0, 1'b0);
    mf(5'h08, v); chk("compare_absent", v, 32'd0);
    mf(5'h09, v); chk("count_absent", v, 32'd0);
    issue(enc_mt(5'h0C), 32'h4000_0001, 1'b0, 1'b0);
    mf(5'h0C, v); chk("tm_absent", v, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coproc0_v2.md
Name: coproc0_v2

Overview:
Second-generation System Control Coprocessor (COP0) for the 5-stage Ultiparc core. Decodes COP0 instructions in the decode stage and pipelines them to writeback, where register writes commit.
Adds over the first generation:
- parametrised external interrupt lines with mask and pending bits;
- an exception-code field;
- a parametrised interrupt-enable stack;
- a COUNT/COMPARE timer, compiled in optionally.
Sits beside the integer pipeline; the control unit consumes o_irq_pending and o_decode_error.

Parameters:
NIRQ, 6, external interrupt lines (1..8)
IE_STACK_DEPTH, 3, IE levels; level 0 = current IE (2..8)
IVT_ALIGN, 10, low address bits forced zero in IVT base (8..16)
PROCID, 32'h0001_0200, PRID read value

Ports:
clk  in  1  clock
nrst  in  1  async active-low reset
i_exec_stall / i_mem_stall / i_fetch_stall  in  1 each  pipeline stalls; core_stall = OR of all three
o_decode_error  out  1  malformed COP0 instruction in decode
i_except_start  in  1  exception entry
i_except_dly_slt  in  1  faulting instruction is in a delay slot
i_except_code  in  5  exception cause code
i_except_raddr / i_except_raddr_dly  in  32 each  return address, normal / delay slot
i_nullify_decode / _execute / _mem / _wb  in  1 each  stage nullify
i_irq  in  NIRQ  async level interrupt lines
o_irq_pending  out  1  interrupt request to CU
o_cop0_ivtbase  out  32-IVT_ALIGN  IVT base high bits
o_cop0_ie  out  1  current IE
i_instr  in  32  fetched instruction
o_cop0_op_p1  out  1  decode holds a COP0 op
o_cop0_cop_p1  out  5  cop field (MF/MT only, else 0)
o_cop0_reg_no_p1  out  5  rd field
o_cop0_rt_no_p1  out  5  rt field
o_cop0_reg_val_p1  out  32  MF read value
i_cop0_alu_result_p2  in  32  MT data from execute

Behaviour:
Reset is nrst, asynchronous, active-low; clock is clk.

Reset values:
- all registers and pipeline regs = 0; decode instr = NOP;
- o_irq_pending = 0, o_cop0_ie = 0, o_cop0_ivtbase = 0.

Pipeline (decode -> p2 -> p3 -> wb):
- Each stage advances only when !core_stall.
- A nullified stage loads zeros / NOP.
- Decode outputs are combinational from the decode instr.
- MF reads in decode return the pre-write value; there is no forwarding, and the CU interlocks.

Register map (MF value; MT effect):
- 0x08 COMPARE: RW; write clears TI.
- 0x09 COUNT: RW.
- 0x0A IVT: {base, IVT_ALIGN zeros}; write takes bits [31:IVT_ALIGN].
- 0x0B PSR: IE stack levels 1..D-1 at bits [D-2:0].
- 0x0C SR: bit0 IE, bits[8+NIRQ-1:8] IM, bit30 TM.
- 0x0D CAUSE: bit31 BD, bit30 TI, bits[8+NIRQ-1:8] IP, bits[6:2] EXC. Only BD and EXC are writable.
- 0x0E EPC: RW.
- 0x0F PRID: read-only.
- Other register numbers read 0, and writes to them are ignored.

Decode error:
- MF/MT with nonzero bits [10:0].
- CO with nonzero rt/rd/rsvd or func != RFE.
- Any other cop value.

Writeback priority, when !core_stall:
1. Not nullified and instruction is RFE: pop IE stack (level i <= level i+1; top <= 0).
2. Not nullified and instruction is MT: register write.
3. Else if i_except_start:
   - push IE stack (level i+1 <= level i; level 0 <= 0; the top level is lost);
   - BD <= i_except_dly_slt;
   - EPC <= dly ? raddr_dly : raddr;
   - EXC <= i_except_code.
- During core_stall nothing commits, including exception entry.

Interrupts:
- i_irq passes through a 2-flop synchroniser into IP, so IP lags a change by 2 cycles.
- o_irq_pending = IE & (|(IP & IM) | (TI & TM)), registered, so it is 1 cycle after IP/TI.

Optional Feature:
COP0_TIMER_EN

With the macro defined:
- COUNT increments every clk, wrapping 0xFFFF_FFFF -> 0, regardless of stall.
- When COUNT == COMPARE-1 before an increment, TI is set the next cycle (i.e. once COUNT equals COMPARE).
- An MT COUNT in the same cycle wins over the increment.
- An MT COMPARE clears TI, and that clear wins over a simultaneous set.

Without the macro:
- COUNT, COMPARE, TI and TM are absent and read 0.
- Writes to them are ignored.
- The timer term is dropped from o_irq_pending.

Decomposition:
- Shared package/header: COP0 register numbers, CAUSE/SR bit positions, EXC code constants, NOP.
- One sub-module, cop0_irq_sync: a NIRQ-wide 2-flop synchroniser.

Test Plan:
1. MT SR = 0x0000_0301 (NIRQ=6), then i_irq[1]=1 -> IP bit9 set 2 cycles later; o_irq_pending=1 one cycle after that.
2. i_except_start with dly_slt=1, code=5'h0C, raddr_dly=0x100 (IE stack 1,1,0) -> EPC=0x100, CAUSE=0x8000_0030, IE stack 0,1,1; then RFE restores IE=1.
3. Exception and a non-nullified MT EPC=0x44 in the same cycle -> MT commits, exception ignored; with i_nullify_wb=1 the exception commits instead.
4. MT IVT=0x1234_5FFF (IVT_ALIGN=10) -> o_cop0_ivtbase=0x048D17; MF IVT returns 0x1234_5C00.
5. Instruction COP0 MF with func=1 -> o_decode_error=1; MT to PRID -> MF PRID still reads PROCID.
6. With COP0_TIMER_EN defined: COMPARE=5, COUNT=0 -> TI set when COUNT reaches 5; MT COMPARE on the same cycle leaves TI=0; COUNT 0xFFFF_FFFF wraps to 0.
